simple_uart_tx_fifo: RTL and testbench
======================================

# simple_uart_tx_fifo

Transmit-side buffer in front of `simple_uart`. It accepts bytes from a system producer through a valid/ready handshake and stores up to 2^DEPTH_LOG2 of them. It drains them one at a time into the UART's `tx_value`/`tx_value_write`/`tx_value_done` interface, so software or a packet engine can burst bytes without tracking the serial line rate.

## Interface

- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..10.

Ports:

- `clock` in 1: single clock domain, shared with `simple_uart`.
- `arst_n` in 1: reset, asynchronous, active-low.
- `wr_value` in 8: byte from producer.
- `wr_valid` in 1: producer offers `wr_value`.
- `wr_ready` out 1: FIFO accepts this cycle.
- `flush` in 1: synchronous discard of all queued bytes.
- `level` out DEPTH_LOG2+1: number of queued bytes, 0..2^DEPTH_LOG2.
- `busy` out 1: high while a byte is owned by the UART or `level` ≠ 0.
- `uart_tx_value` out 8: to `simple_uart.tx_value`.
- `uart_tx_write` out 1: to `simple_uart.tx_value_write`.
- `uart_tx_done` in 1: from `simple_uart.tx_value_done`, a one-cycle pulse at the end of the stop bit.

## Operation

- Write: a byte is accepted on a rising edge where `wr_valid && wr_ready`. It is stored at the write pointer, and the write pointer and `level` increment.
- `wr_ready = (level != 2^DEPTH_LOG2) && !flush`, combinational.
- Write while full: ignored, no state change. The producer must hold `wr_valid`.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. `level` is a separate counter.
- Drain FSM has two states, IDLE and WAIT_DONE.
  - IDLE, `level != 0`: register `uart_tx_value` = head byte and `uart_tx_write` = 1, pop (read pointer +1, `level` −1), go to WAIT_DONE.
  - IDLE, `level == 0`: stay.
  - WAIT_DONE, `uart_tx_done` = 0: stay. `uart_tx_value` is held stable.
  - WAIT_DONE, `uart_tx_done` = 1, `level != 0`: issue the next byte as in IDLE and stay in WAIT_DONE (back-to-back).
  - WAIT_DONE, `uart_tx_done` = 1, `level == 0`: go to IDLE.
- `uart_tx_write` is high for exactly one cycle per byte and never while in WAIT_DONE without a preceding `uart_tx_done`.
- Push and pop on the same edge: `level` is unchanged and both pointers advance.
- Flush: pointers and `level` clear to 0. The write is dropped if `wr_valid` is high in the same cycle. A byte already handed to the UART is not aborted: the FSM stays in WAIT_DONE until `uart_tx_done`, then goes to IDLE.
- `uart_tx_done` in IDLE is ignored.
- `busy = (state == WAIT_DONE) || (level != 0)`.

## Timing

- Reset values: `level` = 0, `wr_ready` = 1, `busy` = 0, `uart_tx_value` = 8'h00, `uart_tx_write` = 0, FSM = IDLE. Memory contents are don't-care.
- Reset mid-transmission clears the FIFO and the FSM immediately. `simple_uart` is reset by the same system reset.
- Write-to-UART latency with the FIFO empty and FSM in IDLE: byte accepted at edge k; `uart_tx_write` is high in the cycle after edge k+1.
- `uart_tx_done` sampled at edge d with data pending: `uart_tx_write` is high in the cycle after edge d, giving one cycle of gap.
- Full throughput: one byte per UART frame (10 bit times) with no idle bit between frames beyond one clock.
- `level` and `busy` are registered and reflect the edge just passed. `wr_ready` follows `level` and `flush` combinationally.

## Structure

- Shared package `simple_uart_pkg`:
  - `UART_DATA_WIDTH` = 8.
  - Drain FSM state encodings `TXF_IDLE` and `TXF_WAIT_DONE`.
  - Reused by any future RX FIFO.
- Sub-module `simple_uart_fifo_ram`: 2^DEPTH_LOG2 × 8 storage, one synchronous write port, combinational read at the read pointer. No reset on the array.
- Pointer, level and FSM logic live in `simple_uart_tx_fifo`.

## Test plan

- Reset, then push 8'h55 with the UART model idle → one `uart_tx_write` pulse with value 0x55 in the cycle after edge k+1. `busy` = 1 until `uart_tx_done`, then 0.
- Push 16 bytes 0x00..0x0F back-to-back with DEPTH_LOG2 = 4 → `wr_ready` drops at `level` = 16. The 17th `wr_valid` is stalled. The UART receives 0x00..0x0F in order, with exactly one `uart_tx_write` per `uart_tx_done`.
- Push continuously for 200 bytes (pattern 0..199) with `simple_uart` in loopback and the serial receive task checking → every byte is received in order, with no stop-bit error and pointers wrapping several times.
- Push on the same edge as a pop at `level` = 3 → `level` stays 3, and the data order is preserved.
- Queue 5 bytes, assert `flush` for one cycle mid-frame while `wr_valid` = 1 → `level` = 0 and the concurrent write is dropped. The in-flight byte completes, and no further `uart_tx_write` occurs.
- Deassert `arst_n` while in WAIT_DONE with `level` = 4 → all outputs take their reset values at once. The first write after release is sent normally.

Source files
------------

// File: rtl/simple_uart_pkg.sv
// Shared definitions for the simple_uart buffering blocks.
// Holds the UART data width and the drain FSM state encodings, so a future
// RX FIFO can reuse the same names and widths.
package simple_uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic {
    TXF_IDLE      = 1'b0,
    TXF_WAIT_DONE = 1'b1
  } txf_state_t;

endpackage

// File: rtl/simple_uart_fifo_ram.sv
// Byte storage for the UART FIFOs: 2^DEPTH_LOG2 entries.
// It has one synchronous write port and a combinational read at the read
// pointer. The array has no reset because stale entries are never read
// while the FIFO level says they are empty.
module simple_uart_fifo_ram
  import simple_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [DEPTH_LOG2-1:0]      wr_addr,
  input  logic [UART_DATA_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0]      rd_addr,
  output logic [UART_DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [UART_DATA_WIDTH-1:0] mem [DEPTH];

  // Store an accepted byte at the write pointer.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simple_uart_tx_fifo.sv
// Transmit buffer in front of simple_uart.
// Bytes arrive through a valid/ready handshake and are queued. A two-state
// drain FSM hands them to the UART one at a time. Each handoff is a
// one-cycle tx_write pulse, and the FSM then waits for tx_done before it
// issues the next byte.
module simple_uart_tx_fifo
  import simple_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       clock,
  input  logic                       arst_n,
  input  logic [UART_DATA_WIDTH-1:0] wr_value,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       flush,
  output logic [DEPTH_LOG2:0]        level,
  output logic                       busy,
  output logic [UART_DATA_WIDTH-1:0] uart_tx_value,
  output logic                       uart_tx_write,
  input  logic                       uart_tx_done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  txf_state_t state;
  txf_state_t state_next;

  logic [DEPTH_LOG2-1:0]      wr_ptr;
  logic [DEPTH_LOG2-1:0]      rd_ptr;
  logic [DEPTH_LOG2:0]        level_q;
  logic [UART_DATA_WIDTH-1:0] head_byte;
  logic [UART_DATA_WIDTH-1:0] tx_value_q;
  logic                       tx_write_q;
  logic                       push;
  logic                       issue;
  logic                       has_data;

  // Flush blocks acceptance so a write in the flush cycle is dropped cleanly.
  assign wr_ready = (level_q != LEVEL_FULL) && !flush;
  assign push     = wr_valid && wr_ready;
  assign has_data = (level_q != '0);

  simple_uart_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock  (clock),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data(wr_value),
    .rd_addr(rd_ptr),
    .rd_data(head_byte)
  );

  // Drain FSM state register.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state <= TXF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain decision: issue the head byte when idle or when the UART just finished.
  // Flush takes priority, so nothing queued at flush time is ever issued.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      TXF_IDLE: begin
        if (has_data && !flush) begin
          issue      = 1'b1;
          state_next = TXF_WAIT_DONE;
        end
      end
      TXF_WAIT_DONE: begin
        if (uart_tx_done) begin
          if (has_data && !flush) begin
            issue = 1'b1;
          end else begin
            state_next = TXF_IDLE;
          end
        end
      end
      default: begin
        state_next = TXF_IDLE;
      end
    endcase
  end

  // Pointers wrap modulo depth. The level counter tells full from empty.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, issue})
        2'b10:   level_q <= level_q + LEVEL_ONE;
        2'b01:   level_q <= level_q - LEVEL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Registered UART handoff. The value is held until the next issue.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      tx_value_q <= '0;
      tx_write_q <= 1'b0;
    end else begin
      tx_write_q <= issue;
      if (issue) begin
        tx_value_q <= head_byte;
      end
    end
  end

  assign uart_tx_value = tx_value_q;
  assign uart_tx_write = tx_write_q;
  assign level         = level_q;
  assign busy          = (state == TXF_WAIT_DONE) || has_data;

endmodule

// File: tb/tb_simple_uart_tx_fifo.sv
// Testbench for simple_uart_tx_fifo.
// A queue-based model of the buffer predicts every output on every cycle.
// A UART stand-in answers each tx_write with a tx_done pulse after a random
// latency, or leaves tx_done to the directed sequences in manual mode.
module tb_simple_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                  clock = 1'b0;
  logic                  arst_n;
  logic [7:0]            wr_value;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  flush;
  logic [DEPTH_LOG2:0]   level;
  logic                  busy;
  logic [7:0]            uart_tx_value;
  logic                  uart_tx_write;
  logic                  uart_tx_done;
  logic                  auto_done;
  logic                  man_done;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  bit           exp_inflight = 1'b0;
  bit           exp_write    = 1'b0;
  logic [7:0]   exp_value    = 8'h00;

  byte unsigned rx_log[$];
  bit           auto_en   = 1'b0;
  int           uart_cnt  = 0;
  bit           last_ready;

  assign uart_tx_done = auto_done | man_done;

  simple_uart_tx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clock        (clock),
    .arst_n       (arst_n),
    .wr_value     (wr_value),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .level        (level),
    .busy         (busy),
    .uart_tx_value(uart_tx_value),
    .uart_tx_write(uart_tx_write),
    .uart_tx_done (uart_tx_done)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of pending bytes plus a flag for the byte the UART owns.
  initial begin
    forever begin
      @(posedge clock or negedge arst_n);
      if (!arst_n) begin
        exp_q.delete();
        exp_inflight = 1'b0;
        exp_write    = 1'b0;
        exp_value    = 8'h00;
      end else begin
        bit accept;
        accept    = wr_valid && (exp_q.size() != DEPTH) && !flush;
        exp_write = 1'b0;
        if (flush) begin
          exp_q.delete();
          if (exp_inflight && uart_tx_done) exp_inflight = 1'b0;
        end else if ((!exp_inflight || uart_tx_done) && exp_q.size() != 0) begin
          exp_value    = exp_q.pop_front();
          exp_write    = 1'b1;
          exp_inflight = 1'b1;
        end else if (exp_inflight && uart_tx_done) begin
          exp_inflight = 1'b0;
        end
        if (accept) exp_q.push_back(wr_value);
      end
    end
  end

  // UART stand-in: log each handed-off byte and, in auto mode, answer with tx_done.
  initial begin
    auto_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      auto_done = 1'b0;
      if (!arst_n) begin
        uart_cnt = 0;
      end else if (uart_tx_write) begin
        rx_log.push_back(uart_tx_value);
        uart_cnt = auto_en ? int'($urandom_range(2, 10)) : 0;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) auto_done = 1'b1;
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    check("level", 32'(level), exp_q.size());
    check("busy", 32'(busy), 32'(exp_inflight || exp_q.size() != 0));
    check("wr_ready", 32'(wr_ready), 32'(exp_q.size() != DEPTH && !flush));
    check("tx_write", 32'(uart_tx_write), 32'(exp_write));
    check("tx_value", 32'(uart_tx_value), 32'(exp_value));
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    last_ready = wr_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    wr_valid = 1'b1;
    wr_value = b;
    do begin
      tick();
      n++;
    end while (!last_ready && n < 100);
    check("push_accepted", 32'(last_ready), 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_rx(input int count, input int max_cycles);
    int n = 0;
    while (rx_log.size() < count && n < max_cycles) begin
      tick();
      n++;
    end
    check("rx_count", rx_log.size(), count);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  // Directed sequences followed by a long randomized stream.
  initial begin
    arst_n   = 1'b0;
    wr_value = 8'h00;
    wr_valid = 1'b0;
    flush    = 1'b0;
    man_done = 1'b0;
    repeat (3) tick();

    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_write", 32'(uart_tx_write), 32'd0);
    check("rst_value", 32'(uart_tx_value), 32'h00);
    arst_n = 1'b1;
    tick();

    // Single byte: the write pulse comes one edge after acceptance.
    auto_en = 1'b1;
    push_byte(8'h55);
    check("t1_level", 32'(level), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_no_write_yet", 32'(uart_tx_write), 32'd0);
    tick();
    check("t1_write", 32'(uart_tx_write), 32'd1);
    check("t1_value", 32'(uart_tx_value), 32'h55);
    check("t1_level_drained", 32'(level), 32'd0);
    wait_idle(50);
    check("t1_rx_count", rx_log.size(), 32'd1);
    check("t1_rx_byte", 32'(rx_log[0]), 32'h55);

    // Fill: the first byte goes to the UART, then 16 more fill the FIFO.
    auto_en = 1'b0;
    rx_log.delete();
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    check("t2_level_full", 32'(level), 32'd16);
    check("t2_ready_full", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_value = 8'h11;
    repeat (3) tick();
    check("t2_level_stalled", 32'(level), 32'd16);
    auto_en = 1'b1;
    pulse_done();
    push_byte(8'h11);
    wait_rx(18, 600);
    for (int i = 0; i < 18; i++) check("t2_rx_order", 32'(rx_log[i]), i);
    wait_idle(100);

    // Push and pop on the same edge at level 3.
    auto_en = 1'b0;
    rx_log.delete();
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
    check("t3_level_before", 32'(level), 32'd3);
    wr_valid = 1'b1;
    wr_value = 8'hA4;
    man_done = 1'b1;
    tick();
    wr_valid = 1'b0;
    man_done = 1'b0;
    check("t3_level_same", 32'(level), 32'd3);
    check("t3_write", 32'(uart_tx_write), 32'd1);
    check("t3_value", 32'(uart_tx_value), 32'hA1);
    tick();
    auto_en = 1'b1;
    pulse_done();
    wait_rx(5, 200);
    for (int i = 0; i < 5; i++) check("t3_rx_order", 32'(rx_log[i]), 32'hA0 + 32'(i));
    wait_idle(100);

    // Flush mid-frame with a concurrent write.
    auto_en = 1'b0;
    rx_log.delete();
    for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i));
    check("t4_level_before", 32'(level), 32'd5);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_value = 8'hEE;
    #1;
    check("t4_ready_flush", 32'(wr_ready), 32'd0);
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("t4_level_flushed", 32'(level), 32'd0);
    check("t4_busy_inflight", 32'(busy), 32'd1);
    check("t4_no_write", 32'(uart_tx_write), 32'd0);
    repeat (3) tick();
    pulse_done();
    repeat (5) tick();
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_rx_count", rx_log.size(), 32'd1);
    check("t4_rx_byte", 32'(rx_log[0]), 32'hB0);

    // Asynchronous reset while waiting for tx_done with 4 bytes queued.
    rx_log.delete();
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    check("t5_level_before", 32'(level), 32'd4);
    #2;
    arst_n = 1'b0;
    #1;
    check("t5_level", 32'(level), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_write", 32'(uart_tx_write), 32'd0);
    check("t5_value", 32'(uart_tx_value), 32'h00);
    check("t5_ready", 32'(wr_ready), 32'd1);
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    auto_en = 1'b1;
    rx_log.delete();
    push_byte(8'h3C);
    wait_rx(1, 50);
    check("t5_rx_byte", 32'(rx_log[0]), 32'h3C);
    wait_idle(50);

    // Long stream with random producer gaps and random UART latency.
    rx_log.delete();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      push_byte(8'(i));
    end
    wait_rx(200, 6000);
    for (int i = 0; i < 200; i++) check("t6_rx_order", 32'(rx_log[i]), i);
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
